// File: rtl/medfilt_pkg.sv
// Shared types and constants for the median-filter window scheduler.
package medfilt_pkg;

  localparam int COORD_W    = 10;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/medfilt_raster_cnt.sv
// Raster counter over interior window centres (rows/cols 1..N-2), column fastest.
// wrap: column is on its last interior position; last: row is on its last interior row.
module medfilt_raster_cnt
  import medfilt_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 2);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 2);
  localparam logic [COORD_W-1:0] FIRST    = COORD_W'(1);

  assign wrap = (col == COL_LAST);
  assign last = (row == ROW_LAST);

  // Load the first centre at frame start, step in raster order on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= FIRST;
      col <= FIRST;
    end else if (advance) begin
      if (wrap) begin
        col <= FIRST;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/medfilt_sched.sv
// Median-filter window scheduler: issues one 3x3 window at a time for every
// interior pixel, waits for the filter result and hands it out on a
// valid/ready port. Optional WAIT watchdog enabled by MEDFILT_SCHED_TMO_EN.
//
//   state | meaning
//   IDLE  | no frame active, waiting for start
//   ISSUE | win_gen_flag high for the current centre
//   WAIT  | window outstanding, waiting for medfilt_done_flag
//   OUT   | result presented, waiting for out_ready
//   FIN   | frame_done pulse, back to IDLE next
module medfilt_sched
  import medfilt_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               win_gen_flag,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  input  logic               medfilt_done_flag,
  input  logic [DATA_W-1:0]  medfilt_data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [COORD_W-1:0] out_row,
  output logic [COORD_W-1:0] out_col,
  output logic               busy,
  output logic               frame_done,
  output logic               err_tmo
);

  if (IMG_W < 4 || IMG_W > 1024 || IMG_H < 4 || IMG_H > 1024 || TMO_CYC < 1)
  begin : g_param_chk
    $error("medfilt_sched: parameter out of range");
  end

  state_t             state;
  logic               cnt_load;
  logic               cnt_adv;
  logic               last_row;
  logic               col_wrap;
  logic               frame_end;
  logic               tmo_hit;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;

  // Coordinates never move while a window is outstanding or a result is
  // held, so both coordinate ports can come straight from the counter.
  assign win_row   = row;
  assign win_col   = col;
  assign out_row   = row;
  assign out_col   = col;
  assign frame_end = last_row && col_wrap;
  assign cnt_load  = (state == IDLE) && start;
  assign cnt_adv   = (state == OUT) && out_ready && !frame_end;

  medfilt_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .advance (cnt_adv),
    .row     (row),
    .col     (col),
    .last    (last_row),
    .wrap    (col_wrap)
  );

`ifdef MEDFILT_SCHED_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Down-counter reloaded outside WAIT; terminal count on the TMO_CYC-th WAIT cycle.
  assign tmo_hit = (state == WAIT) && !medfilt_done_flag && (tmo_cnt == '0);

  // Watchdog timer and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      if (state != WAIT) tmo_cnt <= TMO_W'(TMO_CYC - 1);
      else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
      if (tmo_hit) err_tmo <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      win_gen_flag <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      win_gen_flag <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state        <= ISSUE;
          win_gen_flag <= 1'b1;
          busy         <= 1'b1;
        end
        ISSUE: state <= WAIT;
        WAIT: if (medfilt_done_flag) begin
          out_data  <= medfilt_data_out;
          out_valid <= 1'b1;
          state     <= OUT;
        end else if (tmo_hit) begin
          state        <= ISSUE;
          win_gen_flag <= 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (frame_end) begin
            state      <= FIN;
            frame_done <= 1'b1;
          end else begin
            state        <= ISSUE;
            win_gen_flag <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_medfilt_sched.sv
// Self-checking bench for medfilt_sched on a 4x4 image with TMO_CYC=8.
// Builds with or without MEDFILT_SCHED_TMO_EN.
module tb_medfilt_sched;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int DW   = 16;
  localparam int TMO  = 8;
  localparam int NRES = (W - 2) * (H - 2);
`ifdef MEDFILT_SCHED_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic          win_gen_flag;
  logic [9:0]    win_row, win_col, out_row, out_col;
  logic          medfilt_done_flag;
  logic [DW-1:0] medfilt_data_out, out_data;
  logic          out_valid, busy, frame_done, err_tmo;

  logic          resp_done, spur_done;
  logic [DW-1:0] resp_data;
  logic          silent = 1'b0, lat_rand = 1'b0, force_en = 1'b0;
  logic [DW-1:0] force_val = '0;

  assign medfilt_done_flag = resp_done | spur_done;
  assign medfilt_data_out  = resp_done ? resp_data : 16'hDEAD;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  medfilt_sched #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .win_gen_flag(win_gen_flag), .win_row(win_row), .win_col(win_col),
    .medfilt_done_flag(medfilt_done_flag), .medfilt_data_out(medfilt_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col),
    .busy(busy), .frame_done(frame_done), .err_tmo(err_tmo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Filter stand-in: answers each launched window after a fixed or random latency.
  int resp_cnt;
  initial begin
    resp_done = 1'b0;
    resp_data = '0;
    resp_cnt  = 0;
    forever begin
      @(posedge clk); #1;
      resp_done = 1'b0;
      if (rst) resp_cnt = 0;
      else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            resp_done = 1'b1;
            resp_data = force_en ? force_val : DW'($urandom);
          end
        end
        if (win_gen_flag && !silent)
          resp_cnt = lat_rand ? int'($urandom_range(1, 5)) : 3;
      end
    end
  end

  // Behavioural model: expectation times derived from the handshake rules.
  int cyc = 0;
  int flag_due, valid_from, fd_due, err_from, issue_cyc, idx, dut_res;
  bit exp_busy, waiting, exp_flag, exp_valid;
  logic [DW-1:0] exp_data;
  int hs_row[$];
  int hs_col[$];

  task automatic model_reset();
    flag_due = -1; valid_from = -1; fd_due = -1; err_from = -1;
    issue_cyc = 0; idx = 0; dut_res = 0;
    exp_busy = 1'b0; waiting = 1'b0; exp_data = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) model_reset();
      else begin
        exp_flag  = (cyc == flag_due);
        exp_valid = (valid_from >= 0) && (cyc >= valid_from);
        check("win_gen_flag", win_gen_flag, exp_flag);
        if (exp_flag) begin
          check("win_row", win_row, 1 + idx / (W - 2));
          check("win_col", win_col, 1 + idx % (W - 2));
        end
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
          check("out_data", out_data, exp_data);
          check("out_row", out_row, 1 + idx / (W - 2));
          check("out_col", out_col, 1 + idx % (W - 2));
        end
        check("frame_done", frame_done, cyc == fd_due);
        check("busy", busy, exp_busy);
        check("err_tmo", err_tmo, (err_from >= 0) && (cyc >= err_from));

        if (out_valid && out_ready) begin
          dut_res++;
          hs_row.push_back(int'(out_row));
          hs_col.push_back(int'(out_col));
        end
        if (frame_done) check("results_per_frame", dut_res, NRES);

        if (exp_flag) begin
          waiting   = 1'b1;
          issue_cyc = cyc;
        end
        if (waiting && cyc > issue_cyc && medfilt_done_flag) begin
          waiting    = 1'b0;
          valid_from = cyc + 1;
          exp_data   = medfilt_data_out;
        end else if (TMO_EN && waiting && cyc == issue_cyc + TMO) begin
          flag_due = cyc + 1;
          if (err_from < 0) err_from = cyc + 1;
        end
        if (exp_valid && out_ready) begin
          idx++;
          valid_from = -1;
          if (idx == NRES) fd_due = cyc + 1;
          else flag_due = cyc + 1;
        end
        if (start && !exp_busy) begin
          exp_busy = 1'b1;
          flag_due = cyc + 1;
          idx      = 0;
          dut_res  = 0;
          hs_row.delete();
          hs_col.delete();
        end
        if (cyc == fd_due) exp_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // sel: 0 out_valid, 1 frame_done, 2 win_gen_flag, 3 err_tmo
  task automatic wait_for(input int sel, input string name, input int maxc);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < maxc && !hit; i++) begin
      case (sel)
        0: hit = out_valid;
        1: hit = frame_done;
        2: hit = win_gen_flag;
        default: hit = err_tmo;
      endcase
      if (!hit) tick();
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s: no event within %0d cycles, expected one", name, maxc);
    end
  endtask

  initial begin
    int exp_r[4];
    int exp_c[4];
    int nflag, gap;
    exp_r = '{1, 1, 2, 2};
    exp_c = '{1, 2, 1, 2};
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; spur_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Spurious done in IDLE, then the first frame with a held first result.
    spur_done = 1'b1; tick(); spur_done = 1'b0; tick();
    check("idle_busy", busy, 0);
    force_en = 1'b1; force_val = 16'h1234;
    start = 1'b1; tick(); start = 1'b0;
    wait_for(0, "first_result", 20);
    force_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) spur_done = 1'b1;
      if (i == 5) start = 1'b1;
      tick();
      spur_done = 1'b0;
      start = 1'b0;
    end
    check("held_out_valid", out_valid, 1);
    check("held_out_data", out_data, 16'h1234);
    out_ready = 1'b1;
    wait_for(1, "frame_done_a", 60);
    check("frame_a_count", hs_row.size(), 4);
    for (int i = 0; i < 4 && i < hs_row.size(); i++) begin
      check("frame_a_row", hs_row[i], exp_r[i]);
      check("frame_a_col", hs_col[i], exp_c[i]);
    end
    tick(); tick();

    // Random latency, random back-pressure, random data.
    lat_rand = 1'b1;
    repeat (3) begin
      bit seen;
      seen = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        seen = frame_done;
      end
      check("rand_frame_done_seen", seen, 1);
      out_ready = 1'b1;
      tick(); tick();
    end
    lat_rand = 1'b0;

    // Reset while the third window is outstanding, then a fresh frame.
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    nflag = 0;
    for (int i = 0; i < 100 && nflag < 3; i++) begin
      if (win_gen_flag) nflag++;
      if (nflag < 3) tick();
    end
    check("third_flag_seen", nflag, 3);
    tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", out_valid, 0);
    repeat (8) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_for(2, "restart_flag", 5);
    check("restart_row", win_row, 1);
    check("restart_col", win_col, 1);
    wait_for(1, "frame_done_restart", 60);
    tick(); tick();

    // Filter silent for the first window.
    silent = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_for(2, "silent_flag", 5);
    silent = 1'b0;
`ifdef MEDFILT_SCHED_TMO_EN
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!win_gen_flag && gap < 50);
    check("tmo_reissue_gap", gap, 9);
    check("tmo_err_set", err_tmo, 1);
    check("tmo_reissue_row", win_row, 1);
    check("tmo_reissue_col", win_col, 1);
    wait_for(1, "frame_done_tmo", 80);
    check("tmo_err_sticky", err_tmo, 1);
`else
    gap = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (win_gen_flag) gap++;
    end
    check("silent_no_reissue", gap, 0);
    check("silent_busy", busy, 1);
    check("silent_no_valid", out_valid, 0);
    check("silent_err_tmo", err_tmo, 0);
`endif
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    tick();
    check("final_err_clear", err_tmo, 0);
    check("final_busy", busy, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
